// File: rtl/ad9914_pkg.sv
// Shared definitions for the AD9914 DRG sweep sequencer: FSM states, register
// map, DRG-enable bit, segment record layout.
package ad9914_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SFR, ST_LOAD, ST_ARM, ST_SWEEP, ST_DWELL, ST_NEXT
  } state_t;

  localparam logic [7:0] ADDR_CFR1       = 8'h00;
  localparam logic [7:0] ADDR_CFR2       = 8'h01;
  localparam logic [7:0] ADDR_CFR3       = 8'h02;
  localparam logic [7:0] ADDR_CFR4       = 8'h03;
  localparam logic [7:0] ADDR_DRG_LOWER  = 8'h04;
  localparam logic [7:0] ADDR_DRG_UPPER  = 8'h05;
  localparam logic [7:0] ADDR_DRG_STEP_P = 8'h06;
  localparam logic [7:0] ADDR_DRG_STEP_N = 8'h07;
  localparam logic [7:0] ADDR_DRG_RATE   = 8'h08;

  localparam logic [31:0] DRG_EN_MASK = 32'h0008_0000;
  localparam logic [3:0]  WR_BYTES    = 4'd4;

  typedef struct packed {
    logic [31:0] lower;
    logic [31:0] upper;
    logic [31:0] step;
    logic [31:0] rate;
    logic [31:0] dwell;
  } seg_t;

endpackage

// File: rtl/ad9914_seg_table.sv
// Sweep segment table: SEG_NUM x 160-bit entries, one synchronous write port,
// one asynchronous read port. No reset, so contents survive rst.
module ad9914_seg_table
  import ad9914_pkg::*;
#(
  parameter int SEG_NUM = 4,
  parameter int SEG_AW  = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SEG_AW-1:0] waddr,
  input  seg_t              wdata,
  input  logic [SEG_AW-1:0] raddr,
  output seg_t              rdata
);

  seg_t mem [SEG_NUM];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < SEG_NUM)) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ad9914_sweep_seq.sv
// AD9914 DRG sweep sequencer: writes SFRs once, then loads/arms/sweeps/dwells
// each table segment. Define AD9914_SWEEP_SEQ_LOOP_EN to honour loop_en.
//   state | meaning
//   IDLE  | waiting for start
//   SFR   | writing SFR_INIT[0..3] to 0x00..0x03
//   LOAD  | writing lower/upper/step/rate of current segment
//   ARM   | rewriting CFR2 with DRG enable (clear for fixed-frequency segments)
//   SWEEP | dctrl high, waiting for dover rise
//   DWELL | holding for dwell+1 cycles
//   NEXT  | advance segment, wrap or finish
module ad9914_sweep_seq
  import ad9914_pkg::*;
#(
  parameter int               SEG_NUM  = 4,
  parameter int               SEG_AW   = 2,
  parameter logic [3:0][31:0] SFR_INIT = {32'h0005_3120, 32'h0000_191C, 32'h0004_2900, 32'h0001_0200}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic [31:0]       cfg_lower,
  input  logic [31:0]       cfg_upper,
  input  logic [31:0]       cfg_step,
  input  logic [31:0]       cfg_rate,
  input  logic [31:0]       cfg_dwell,
  input  logic              start,
  input  logic              stop,
  input  logic [SEG_AW:0]   seg_count,
  input  logic              loop_en,
  output logic              busy,
  output logic              done,
  output logic [SEG_AW-1:0] seg_idx,
  output logic              wr_load,
  output logic [7:0]        wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_bytes,
  input  logic              wr_busy,
  input  logic              wr_finish,
  input  logic              dover,
  output logic              dctrl,
  output logic              osk
);

  localparam logic [SEG_AW:0] SEG_MAX = (SEG_AW+1)'(SEG_NUM);
  localparam logic [SEG_AW:0] ONE     = (SEG_AW+1)'(1);

  state_t            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [SEG_AW-1:0] seg_q, seg_d;
  logic [SEG_AW:0]   cnt_q, cnt_d, seg_clamp, next_idx;
  logic [31:0]       dwell_q, dwell_d;
  logic              wr_load_q, wr_load_d, acc_q, acc_d;
  logic [7:0]        addr_q, addr_d, sel_addr;
  logic [31:0]       data_q, data_d, sel_data;
  logic              dctrl_q, dctrl_d, done_q, done_d, pend_q, pend_d;
  logic              busy_q, dover_q, bytes_en_q;
  logic              wr_st, in_flight, wr_done, abort, more, loop_ok, next_fin;
  seg_t              cfg_entry, cur;

`ifdef AD9914_SWEEP_SEQ_LOOP_EN
  assign loop_ok = loop_en;
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign loop_ok = 1'b0;
`endif

  assign cfg_entry = '{lower: cfg_lower, upper: cfg_upper, step: cfg_step,
                       rate: cfg_rate, dwell: cfg_dwell};

  ad9914_seg_table #(.SEG_NUM(SEG_NUM), .SEG_AW(SEG_AW)) u_table (
    .clk   (clk),
    .we    (cfg_we && (state_q == ST_IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_entry),
    .raddr (seg_q),
    .rdata (cur)
  );

  assign seg_clamp = (seg_count > SEG_MAX) ? SEG_MAX : seg_count;
  assign next_idx  = {1'b0, seg_q} + ONE;
  assign more      = next_idx < cnt_q;
  assign wr_st     = (state_q == ST_SFR) || (state_q == ST_LOAD) || (state_q == ST_ARM);
  assign in_flight = wr_load_q || acc_q;
  assign wr_done   = acc_q && wr_finish && !wr_busy;
  assign abort     = (state_q != ST_IDLE) && (stop || pend_q);
  assign next_fin  = (state_q == ST_NEXT) && !more && !loop_ok && !stop;

  always_comb begin
    sel_addr = 8'h00;
    sel_data = 32'h0;
    case (state_q)
      ST_SFR: begin
        sel_addr = ADDR_CFR1 + {6'd0, step_q};
        sel_data = SFR_INIT[step_q];
      end
      ST_LOAD: begin
        case (step_q)
          2'd0:    begin sel_addr = ADDR_DRG_LOWER;  sel_data = cur.lower; end
          2'd1:    begin sel_addr = ADDR_DRG_UPPER;  sel_data = cur.upper; end
          2'd2:    begin sel_addr = ADDR_DRG_STEP_P; sel_data = cur.step;  end
          default: begin sel_addr = ADDR_DRG_RATE;   sel_data = cur.rate;  end
        endcase
      end
      ST_ARM: begin
        sel_addr = ADDR_CFR2;
        sel_data = (cur.rate == '0) ? (SFR_INIT[1] & ~DRG_EN_MASK) : (SFR_INIT[1] | DRG_EN_MASK);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    seg_d     = seg_q;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;
    wr_load_d = wr_load_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    pend_d    = pend_q;

    // Writer handshake: raise while writer idle, drop on first busy, then wait idle.
    if (wr_st) begin
      if (wr_load_q) begin
        if (wr_busy) begin
          wr_load_d = 1'b0;
          acc_d     = 1'b1;
        end
      end else if (!acc_q && wr_finish && !abort) begin
        wr_load_d = 1'b1;
        addr_d    = sel_addr;
        data_d    = sel_data;
      end else if (wr_done) begin
        acc_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: if (start) begin
        if (seg_clamp == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_SFR;
          seg_d   = '0;
          step_d  = 2'd0;
          cnt_d   = seg_clamp;
        end
      end
      ST_SFR: if (wr_done) begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = ST_LOAD;
      end
      ST_LOAD: if (wr_done) begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = ST_ARM;
      end
      ST_ARM: if (wr_done) begin
        dwell_d = 32'd0;
        state_d = (cur.rate == '0) ? ST_DWELL : ST_SWEEP;
      end
      ST_SWEEP: if (dover && !dover_q) begin
        dwell_d = 32'd0;
        state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (dwell_q == cur.dwell) state_d = ST_NEXT;
        else                      dwell_d = dwell_q + 32'd1;
      end
      ST_NEXT: begin
        step_d = 2'd0;
        if (more) begin
          seg_d   = next_idx[SEG_AW-1:0];
          state_d = ST_LOAD;
        end else if (loop_ok) begin
          seg_d   = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, but lets an accepted write run to completion.
    if (abort) begin
      if (in_flight && !wr_done) begin
        state_d = state_q;
        pend_d  = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        pend_d    = 1'b0;
        wr_load_d = 1'b0;
        acc_d     = 1'b0;
      end
    end

    dctrl_d = ((state_d == ST_ARM) || (state_d == ST_SWEEP)) && (cur.rate != '0) && !abort;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      step_q     <= 2'd0;
      seg_q      <= '0;
      cnt_q      <= '0;
      dwell_q    <= 32'd0;
      wr_load_q  <= 1'b0;
      acc_q      <= 1'b0;
      addr_q     <= 8'h00;
      data_q     <= 32'h0;
      dctrl_q    <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      dover_q    <= 1'b0;
      bytes_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      seg_q      <= seg_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      wr_load_q  <= wr_load_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dctrl_q    <= dctrl_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      busy_q     <= (state_d != ST_IDLE);
      dover_q    <= dover;
      bytes_en_q <= 1'b1;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q || next_fin;
  assign seg_idx  = seg_q;
  assign wr_load  = wr_load_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign wr_bytes = bytes_en_q ? WR_BYTES : 4'd0;
  assign dctrl    = dctrl_q;
  assign osk      = (state_q == ST_SWEEP) && !dover && !stop;

endmodule

// File: tb/tb_ad9914_sweep_seq.sv
// Directed bench for ad9914_sweep_seq: single-segment vector table plus
// hand-written loop, clamp, stop, zero-count and reset sequences.
module tb_ad9914_sweep_seq;

  localparam int SEG_NUM = 4;
  localparam int SEG_AW  = 2;

  logic              clk = 1'b0;
  logic              rst, cfg_we, start, stop, loop_en, dover;
  logic [SEG_AW-1:0] cfg_addr;
  logic [31:0]       cfg_lower, cfg_upper, cfg_step, cfg_rate, cfg_dwell;
  logic [SEG_AW:0]   seg_count;
  logic              busy, done, wr_load, dctrl, osk;
  logic [SEG_AW-1:0] seg_idx;
  logic [7:0]        wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_bytes;
  logic              wr_busy, wr_finish;
  int                wcnt;

  logic [7:0]  log_addr [256];
  logic [31:0] log_data [256];
  int          n_wr = 0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ad9914_sweep_seq #(.SEG_NUM(SEG_NUM), .SEG_AW(SEG_AW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .cfg_step(cfg_step),
    .cfg_rate(cfg_rate), .cfg_dwell(cfg_dwell), .start(start), .stop(stop),
    .seg_count(seg_count), .loop_en(loop_en), .busy(busy), .done(done),
    .seg_idx(seg_idx), .wr_load(wr_load), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_bytes(wr_bytes), .wr_busy(wr_busy), .wr_finish(wr_finish),
    .dover(dover), .dctrl(dctrl), .osk(osk)
  );

  // Register-writer model: accepts when idle, busy for 3 cycles, logs each accepted write.
  always @(posedge clk) begin
    if (!rst) begin
      wr_busy   <= 1'b0;
      wr_finish <= 1'b1;
      wcnt      <= 0;
    end else if (wr_load && !wr_busy && wr_finish) begin
      wr_busy   <= 1'b1;
      wr_finish <= 1'b0;
      wcnt      <= 2;
      if (n_wr < 256) begin
        log_addr[n_wr] <= wr_addr;
        log_data[n_wr] <= wr_data;
      end
      n_wr <= n_wr + 1;
    end else if (wr_busy) begin
      if (wcnt == 0) begin
        wr_busy   <= 1'b0;
        wr_finish <= 1'b1;
      end else begin
        wcnt <= wcnt - 1;
      end
    end
  end

  typedef struct {
    logic [31:0] lower, upper, stp, rate, dwell;
    int          exp_lat;
    logic [31:0] exp_arm;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_seg_idx"}, 32'(seg_idx), 0);
    chk({tag, "_wr_load"}, 32'(wr_load), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_bytes"}, 32'(wr_bytes), 0);
    chk({tag, "_dctrl"}, 32'(dctrl), 0);
    chk({tag, "_osk"}, 32'(osk), 0);
  endtask

  task automatic prog(input logic [SEG_AW-1:0] a, input vec_t v);
    cfg_we = 1'b1; cfg_addr = a;
    cfg_lower = v.lower; cfg_upper = v.upper; cfg_step = v.stp;
    cfg_rate = v.rate; cfg_dwell = v.dwell;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Runs a single-segment sequence on seg0 and checks writes, sweep outputs and dwell latency.
  task automatic run(input string tag, input vec_t v, input bit do_prog);
    logic [7:0]  exp_a [9];
    logic [31:0] exp_d [9];
    int base, lat;
    bit ok, osk_bad;
    exp_a = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h01};
    exp_d = '{32'h0001_0200, 32'h0004_2900, 32'h0000_191C, 32'h0005_3120,
              v.lower, v.upper, v.stp, v.rate, v.exp_arm};
    if (do_prog) prog(0, v);
    base = n_wr; osk_bad = 1'b0;
    seg_count = 1; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (osk) osk_bad = 1'b1;
      if ((n_wr - base == 9) && wr_finish) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_arm_wait"}, 32'(ok), 1);
    @(negedge clk);
    chk({tag, "_wr_bytes"}, 32'(wr_bytes), 4);
    if (v.rate != 0) begin
      chk({tag, "_sweep_osk"}, 32'(osk), 1);
      chk({tag, "_sweep_dctrl"}, 32'(dctrl), 1);
      dover = 1'b1;
      #1;
      chk({tag, "_sweep_osk_dover"}, 32'(osk), 0);
      @(negedge clk);
      chk({tag, "_dwell_dctrl"}, 32'(dctrl), 0);
    end
    lat = 0; ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
      lat++;
      if (osk) osk_bad = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(ok), 1);
    chk({tag, "_done_lat"}, 32'(lat), 32'(v.exp_lat));
    dover = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_osk_off"}, 32'(osk_bad), 0);
    chk({tag, "_wr_count"}, 32'(n_wr - base), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[(base + i) % 256]), 32'(exp_a[i]));
      chk($sformatf("%s_data%0d", tag, i), log_data[(base + i) % 256], exp_d[i]);
    end
  endtask

  // Multi-segment run: records the seg_idx sequence, optionally stops after stop_at segments.
  task automatic trace(input string tag, input logic [SEG_AW:0] cnt, input logic lp,
                       input int stop_at, input int exp_n, input int modulus);
    int q [$];
    int base, sfr_n, act;
    bit ok, stopped;
    base = n_wr; stopped = 1'b0; ok = 1'b0;
    seg_count = cnt; loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy && (q.size() == 0 || q[$] != int'(seg_idx))) q.push_back(int'(seg_idx));
      if (stop_at != 0 && q.size() == stop_at && !stopped) begin
        stop = 1'b1; stopped = 1'b1;
      end else begin
        stop = 1'b0;
      end
      @(negedge clk);
    end
    stop = 1'b0; loop_en = 1'b0;
    chk({tag, "_done_seen"}, 32'(ok), 1);
    sfr_n = 0;
    for (int i = base; i < n_wr; i++) if (log_addr[i % 256] == 8'h00) sfr_n++;
    chk({tag, "_sfr_once"}, 32'(sfr_n), 1);
    chk({tag, "_seg_n"}, 32'(q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      act = (i < q.size()) ? q[i] : -1;
      chk($sformatf("%s_seg%0d", tag, i), 32'(act), 32'(i % modulus));
    end
    @(negedge clk);
  endtask

  initial begin
    int base, snap;
    bit ok;
    vec_t fx;

    vt[0] = '{lower: 100, upper: 200, stp: 1, rate: 32'h0004_0004, dwell: 10,
              exp_lat: 11, exp_arm: 32'h000C_2900};
    vt[1] = '{lower: 32'h1000, upper: 32'h2000, stp: 32'h10, rate: 0, dwell: 5,
              exp_lat: 6, exp_arm: 32'h0004_2900};
    vt[2] = '{lower: 5, upper: 6, stp: 1, rate: 32'h0001_0001, dwell: 0,
              exp_lat: 1, exp_arm: 32'h000C_2900};
    vt[3] = '{lower: 7, upper: 9, stp: 2, rate: 0, dwell: 0,
              exp_lat: 1, exp_arm: 32'h0004_2900};

    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; start = 1'b0; stop = 1'b0;
    loop_en = 1'b0; dover = 1'b0; seg_count = '0;
    cfg_lower = 0; cfg_upper = 0; cfg_step = 0; cfg_rate = 0; cfg_dwell = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run($sformatf("vec%0d", i), vt[i], 1'b1);

    for (int i = 0; i < 4; i++) begin
      fx = '{lower: 32'(i * 16), upper: 32'(i * 16 + 8), stp: 1, rate: 0, dwell: 1,
             exp_lat: 2, exp_arm: 32'h0004_2900};
      prog(SEG_AW'(i), fx);
    end
`ifdef AD9914_SWEEP_SEQ_LOOP_EN
    trace("loop", 3'd3, 1'b1, 4, 4, 3);
`else
    trace("noloop", 3'd3, 1'b1, 0, 3, 3);
`endif
    trace("clamp", 3'd7, 1'b0, 0, 4, 4);

    // Stop during the upper-limit write, with a stray start while busy.
    prog(0, vt[0]);
    base = n_wr; seg_count = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      start = (t == 3);
      if (wr_load && wr_addr == 8'h05) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    chk("stop_wait_addr5", 32'(ok), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("stop_done_seen", 32'(ok), 1);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_dctrl", 32'(dctrl), 0);
    chk("stop_wr_count", 32'(n_wr - base), 6);
    chk("stop_last_addr", 32'(log_addr[(n_wr + 255) % 256]), 5);
    snap = n_wr;
    repeat (4) @(negedge clk);
    chk("stop_no_more_writes", 32'(n_wr), 32'(snap));

    seg_count = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_wr_load", 32'(wr_load), 0);
    @(negedge clk);
    chk("zero_done_pulse", 32'(done), 0);
    chk("zero_no_writes", 32'(n_wr), 32'(snap));

    // Reset during SWEEP, after an attempted table write while busy.
    base = n_wr; seg_count = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 0; cfg_lower = 999; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0; ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if ((n_wr - base == 9) && wr_finish) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_arm_wait", 32'(ok), 1);
    @(negedge clk);
    chk("rst_pre_osk", 32'(osk), 1);
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst_sweep");
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 0);
    end
    run("restart", vt[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
